// File: rtl/instr_mem_loader.sv
// Byte-stream loader that fills instruction memory with big-endian 16-bit words while holding the CPU.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int PROG_CTR_WID = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              byte_in,
    input  logic                    byte_valid,
    output logic                    byte_ready,
    output logic                    wr_en,
    output logic [PROG_CTR_WID-1:0] wr_addr,
    output logic [15:0]             wr_data,
    output logic                    cpu_hold,
    output logic                    load_done,
    output logic                    len_err,
    output logic                    chk_err
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, CHK} state_t;
`else
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE} state_t;
`endif

    // Header lengths are compared in 17 bits so a full-depth load is representable
    localparam logic [16:0] DEPTH = 17'(1) << PROG_CTR_WID;

    state_t      state;
    logic [15:0] word_len;
    logic [15:0] word_cnt;
    logic        xfer;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  run_xor;
`endif

    assign xfer = byte_valid && byte_ready;

    // byte_ready and wr_en are registered alongside every state change
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cpu_hold   <= 1'b0;
            load_done  <= 1'b0;
            len_err    <= 1'b0;
            chk_err    <= 1'b0;
            word_len   <= '0;
            word_cnt   <= '0;
`ifdef LOADER_CHECKSUM_EN
            run_xor    <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= LEN_HI;
                        byte_ready <= 1'b1;
                        cpu_hold   <= 1'b1;
                        load_done  <= 1'b0;
                        len_err    <= 1'b0;
                        chk_err    <= 1'b0;
                        wr_addr    <= '0;
                        word_len   <= '0;
                        word_cnt   <= '0;
`ifdef LOADER_CHECKSUM_EN
                        run_xor    <= '0;
`endif
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        word_len[15:8] <= byte_in;
                        state          <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        word_len[7:0] <= byte_in;
                        if ({word_len[15:8], byte_in} == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state      <= CHK;
`else
                            state      <= DONE;
                            byte_ready <= 1'b0;
                            load_done  <= 1'b1;
                            cpu_hold   <= 1'b0;
`endif
                        end else if ({1'b0, word_len[15:8], byte_in} > DEPTH) begin
                            state      <= DONE;
                            byte_ready <= 1'b0;
                            len_err    <= 1'b1;
                            load_done  <= 1'b1;
                            cpu_hold   <= 1'b0;
                        end else begin
                            state <= DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    if (xfer) begin
                        wr_data[15:8] <= byte_in;
`ifdef LOADER_CHECKSUM_EN
                        run_xor       <= run_xor ^ byte_in;
`endif
                        state         <= DATA_LO;
                    end
                end
                DATA_LO: begin
                    if (xfer) begin
                        wr_data[7:0] <= byte_in;
`ifdef LOADER_CHECKSUM_EN
                        run_xor      <= run_xor ^ byte_in;
`endif
                        state        <= WRITE;
                        byte_ready   <= 1'b0;
                        wr_en        <= 1'b1;
                    end
                end
                WRITE: begin
                    // After the last word of a full-depth load the address wraps to 0 unused
                    wr_addr  <= wr_addr + PROG_CTR_WID'(1);
                    word_cnt <= word_cnt + 16'd1;
                    if (word_cnt + 16'd1 == word_len) begin
`ifdef LOADER_CHECKSUM_EN
                        state      <= CHK;
                        byte_ready <= 1'b1;
`else
                        state      <= DONE;
                        load_done  <= 1'b1;
                        cpu_hold   <= 1'b0;
`endif
                    end else begin
                        state      <= DATA_HI;
                        byte_ready <= 1'b1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                    if (xfer) begin
                        chk_err    <= (byte_in != run_xor);
                        state      <= DONE;
                        byte_ready <= 1'b0;
                        load_done  <= 1'b1;
                        cpu_hold   <= 1'b0;
                    end
                end
`endif
                default: begin
                    state      <= IDLE;
                    byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: a stream-level model queues expected writes, a monitor checks them.
// Define LOADER_CHECKSUM_EN for both files to exercise the checksum byte.
module tb_instr_mem_loader;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         wr_en;
    logic [W-1:0] wr_addr;
    logic [15:0]  wr_data;
    logic         cpu_hold;
    logic         load_done;
    logic         len_err;
    logic         chk_err;

    typedef struct packed {
        logic [W-1:0] addr;
        logic [15:0]  data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] stream[$];
    logic       exp_len_err;
    logic       exp_chk_err;
    int         n_cmp = 0;
    int         n_bad = 0;

    instr_mem_loader #(.PROG_CTR_WID(W)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .load_done(load_done), .len_err(len_err), .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expected write
    always @(negedge clk) begin
        wr_t e;
        if (!rst && wr_en) begin
            compare("byte_ready_during_write", {31'd0, byte_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("[TB] FAIL unexpected_write: got write %0h@%0h, expected none", wr_data, wr_addr);
            end else begin
                e = exp_q.pop_front();
                compare("wr_addr", {28'd0, wr_addr}, {28'd0, e.addr});
                compare("wr_data", {16'd0, wr_data}, {16'd0, e.data});
            end
        end
    end

    // Reference model: derive every write and flag directly from the byte stream
    task automatic model_load();
        int n;
        logic [7:0] x;
        wr_t e;
        exp_q.delete();
        n = int'({stream[0], stream[1]});
        exp_len_err = (n > (1 << W));
        exp_chk_err = 1'b0;
        x = 8'h00;
        if (!exp_len_err) begin
            for (int i = 0; i < n; i++) begin
                e.addr = W'(i);
                e.data = {stream[2 + 2*i], stream[3 + 2*i]};
                x = x ^ stream[2 + 2*i] ^ stream[3 + 2*i];
                exp_q.push_back(e);
            end
`ifdef LOADER_CHECKSUM_EN
            exp_chk_err = (stream[2 + 2*n] != x);
`endif
        end
    endtask

    task automatic add_checksum(input bit corrupt);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 2; i < stream.size(); i++) x = x ^ stream[i];
        stream.push_back(corrupt ? (x ^ 8'h01) : x);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int waited;
        byte_valid = 1'b0;
        repeat ($urandom_range(0, max_gap)) @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
        waited     = 0;
        while (!byte_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!byte_ready) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL byte_ready_timeout: got byte_ready=0 for 100 cycles, expected 1");
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int max_gap, input bit poke_start);
        model_load();
        pulse_start();
        for (int i = 0; i < stream.size(); i++) begin
            if (poke_start && i == 3) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(stream[i], max_gap);
        end
    endtask

    task automatic checkOutput(input string tag, input int max_wait);
        int w;
        w = 0;
        while (!load_done && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        compare({tag, "_load_done"}, {31'd0, load_done}, 32'd1);
        compare({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        compare({tag, "_len_err"}, {31'd0, len_err}, {31'd0, exp_len_err});
        compare({tag, "_chk_err"}, {31'd0, chk_err}, {31'd0, exp_chk_err});
        compare({tag, "_pending_writes"}, exp_q.size(), 32'd0);
        compare({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
    endtask

    task automatic checkReset(input string tag);
        compare({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
        compare({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        compare({tag, "_wr_addr"}, {28'd0, wr_addr}, 32'd0);
        compare({tag, "_wr_data"}, {16'd0, wr_data}, 32'd0);
        compare({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        compare({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
        compare({tag, "_len_err"}, {31'd0, len_err}, 32'd0);
        compare({tag, "_chk_err"}, {31'd0, chk_err}, 32'd0);
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (2) @(negedge clk);
        checkReset("reset");
        rst = 1'b0;

        stream = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF};
`ifdef LOADER_CHECKSUM_EN
        add_checksum(1'b0);
`endif
        applyStimulus(0, 1'b0);
        checkOutput("basic", 5);

        stream = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        add_checksum(1'b0);
`endif
        applyStimulus(0, 1'b0);
        checkOutput("zero_len", 2);

        stream = '{8'h00, 8'h11};
        applyStimulus(1, 1'b0);
        checkOutput("len_err", 2);

        stream = '{8'h00, 8'h10};
        for (int i = 0; i < 32; i++) stream.push_back(8'($urandom_range(0, 255)));
`ifdef LOADER_CHECKSUM_EN
        add_checksum(1'b0);
`endif
        applyStimulus(2, 1'b0);
        checkOutput("full_depth", 5);

        stream = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef LOADER_CHECKSUM_EN
        add_checksum(1'b0);
`endif
        applyStimulus(5, 1'b1);
        checkOutput("backpressure", 5);

        // Reset after three data bytes; the second word must never be written
        stream = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
        model_load();
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(stream[i], 1);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checkReset("mid_reset");
        rst = 1'b0;
        stream = '{8'h00, 8'h01, 8'h55, 8'hAA};
`ifdef LOADER_CHECKSUM_EN
        add_checksum(1'b0);
`endif
        applyStimulus(0, 1'b0);
        checkOutput("after_reset", 5);

`ifdef LOADER_CHECKSUM_EN
        stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
        applyStimulus(0, 1'b0);
        checkOutput("chk_good", 5);
        stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
        applyStimulus(0, 1'b0);
        checkOutput("chk_bad", 5);
`endif

        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(0, 18);
            stream = '{8'h00, 8'(n)};
            if (n <= (1 << W)) begin
                for (int i = 0; i < 2*n; i++) stream.push_back(8'($urandom_range(0, 255)));
`ifdef LOADER_CHECKSUM_EN
                add_checksum(1'($urandom_range(0, 1)));
`endif
            end
            applyStimulus(3, 1'($urandom_range(0, 1)) && n > 0);
            checkOutput("random", 5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
